lcd_wr_arbiter: RTL and testbench

- Shares the single LCD write FIFO (17-bit words: bit16 = command/data sign, bits15:0 = payload) between several drawing requesters: init sequencer, map painter, tank/bullet sprite painters.
- Grants whole transactions (window-set commands plus pixel burst) atomically, so command/data sequences never interleave.
- Sits between the requesters and the FIFO write port (winc/wdata/wfull).
- Round-robin among requesters; optional absolute priority for requester 0 (init); per-grant watchdog.

---
 rtl/lcd_pkg.sv | 28 ++
 rtl/lcd_wr_arbiter_rr_pick.sv | 40 ++++
 rtl/lcd_wr_arbiter.sv | 152 +++++++++++++++
 tb/tb_lcd_wr_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: FIFO word layout, arbiter state encoding and frame size.
// Contents:
//   LCD_WORD_W / LCD_SIGN_BIT - 17-bit FIFO word, bit 16 selects command (1) or data (0)
//   LCD_PIXELS                - pixels per frame, used by requesters to size bursts
//   ARB_IDLE/ARB_XFER/ARB_REL - write-arbiter state encodings
package lcd_pkg;

    localparam int unsigned LCD_WORD_W   = 17;
    localparam int unsigned LCD_SIGN_BIT = 16;
    localparam int unsigned LCD_PIXELS   = 76800;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_XFER = 2'd1;
    localparam logic [1:0] ARB_REL  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ARB_IDLE,
        ST_XFER = ARB_XFER,
        ST_REL  = ARB_REL
    } arb_state_e;

    // Payload view of one FIFO word.
    typedef struct packed {
        logic        is_cmd;
        logic [15:0] payload;
    } lcd_word_t;

endpackage

// File: rtl/lcd_wr_arbiter_rr_pick.sv
// Round-robin pick: first set request strictly after i_ptr, wrapping modulo NUM_REQ.
// Ports:
//   i_req    - request vector
//   i_ptr    - index of the previous winner
//   o_onehot - one-hot winner (zero when no request)
//   o_idx    - winner index
//   o_any    - at least one request present
module rr_pick #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    int unsigned w_cand;

    // Scan ptr+1 .. ptr+NUM_REQ; wrap by subtraction so non-power-of-2 counts work.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_cand   = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = 32'(i_ptr) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!o_any && i_req[PTR_W'(w_cand)]) begin
                o_any                    = 1'b1;
                o_idx                    = PTR_W'(w_cand);
                o_onehot[PTR_W'(w_cand)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_wr_arbiter.sv
// Shares the LCD write FIFO between drawing requesters, granting whole
// transactions so command/data sequences never interleave.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   req/valid/last  - per-requester transaction request, word valid, final word
//   data            - flattened words, requester i at [i*DATA_W +: DATA_W]
//   gnt             - registered one-hot grant
//   ready           - per-requester word accept (combinational)
//   wfull/winc/wdata- FIFO write port
//   busy            - a grant is active (XFER or REL)
//   timeout_err     - one-cycle pulse when the watchdog releases a grant
module lcd_wr_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = LCD_WORD_W,
    parameter int unsigned TIMEOUT = 1023,
    parameter bit          PRIO0   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        valid,
    input  logic [NUM_REQ-1:0]        last,
    input  logic [NUM_REQ*DATA_W-1:0] data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ready,
    input  logic                      wfull,
    output logic                      winc,
    output logic [DATA_W-1:0]         wdata,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam bit WD_EN = (TIMEOUT != 0);

    arb_state_e          r_state;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [CNT_W-1:0]    r_idle_cnt;
    logic                r_busy;
    logic                r_timeout_err;

    logic [NUM_REQ-1:0]  w_pick_onehot;
    logic [PTR_W-1:0]    w_pick_idx;
    logic                w_pick_any;
    logic [NUM_REQ-1:0]  w_sel_onehot;
    logic [PTR_W-1:0]    w_sel_idx;
    logic                w_xfer;
    logic                w_gv;
    logic                w_acc;
    logic                w_acc_last;
    logic                w_req_held;
    logic                w_idle;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_wd_trip;
    logic [DATA_W-1:0]   w_wdata;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .i_req    (req),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // Requester 0 (init) overrides round-robin, but only when picking from IDLE.
    assign w_sel_onehot = (PRIO0 && req[0]) ? {{(NUM_REQ-1){1'b0}}, 1'b1} : w_pick_onehot;
    assign w_sel_idx    = (PRIO0 && req[0]) ? '0 : w_pick_idx;

    assign w_xfer     = (r_state == ST_XFER);
    assign w_gv       = |(valid & r_gnt);
    assign w_acc      = w_xfer & w_gv & ~wfull;
    assign w_acc_last = w_acc & (|(valid & last & r_gnt));
    assign w_req_held = |(req & r_gnt);
    // Idle means the granted source has nothing to offer while the FIFO could take it.
    assign w_idle     = w_xfer & ~w_gv & ~wfull;
    assign w_cnt_inc  = (r_idle_cnt == CNT_MAX) ? r_idle_cnt : r_idle_cnt + CNT_W'(1);
    assign w_wd_trip  = WD_EN && w_idle && (w_cnt_inc == CNT_MAX);

    // Grant is one-hot, so OR-ing the masked slices is a mux.
    always_comb begin
        w_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gnt[i]) begin
                w_wdata = w_wdata | data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Arbitration FSM; gnt clears on the edge leaving XFER so REL is a true bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_gnt         <= '0;
            r_rr_ptr      <= PTR_W'(NUM_REQ - 1);
            r_idle_cnt    <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_gnt    <= w_sel_onehot;
                        r_rr_ptr <= w_sel_idx;
                        r_busy   <= 1'b1;
                        r_state  <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_acc_last || !w_req_held) begin
                        r_state    <= ST_REL;
                        r_gnt      <= '0;
                        r_idle_cnt <= '0;
                    end else if (w_wd_trip) begin
                        r_state       <= ST_REL;
                        r_gnt         <= '0;
                        r_idle_cnt    <= w_cnt_inc;
                        r_timeout_err <= 1'b1;
                    end else if (w_acc) begin
                        r_idle_cnt <= '0;
                    end else if (w_idle) begin
                        r_idle_cnt <= w_cnt_inc;
                    end
                end
                ST_REL: begin
                    r_gnt      <= '0;
                    r_idle_cnt <= '0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;
    assign ready       = {NUM_REQ{w_xfer & ~wfull}} & r_gnt;
    assign winc        = w_acc;
    assign wdata       = w_wdata;

endmodule

// File: tb/tb_lcd_wr_arbiter.sv
// Bench for lcd_wr_arbiter: grant-selection table plus multi-cycle sequences,
// FIFO writes checked against an in-order scoreboard.
module tb_lcd_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 17;
    localparam int TO = 15;
    // Last word on the bus in cycle n, REL in n+1, IDLE in n+2, new gnt visible in n+3.
    localparam int GAP_EXP = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req, valid, last, gnt, ready;
    logic [N*W-1:0]    data;
    logic              wfull, winc, busy, timeout_err;
    logic [W-1:0]      wdata;

    bit                src_en   [N];
    bit                src_mute [N];
    int                src_pos  [N];
    int                src_len  [N];
    int                src_blen [N];
    logic [W-1:0]      src_words[N][8];

    int                checks = 0;
    int                errors = 0;
    logic [W-1:0]      exp_q[$];
    int                gnt_log[$];
    int                gap_log[$];
    int                cyc = 0;
    int                last_cyc = 0;
    logic [N-1:0]      prev_gnt;

    typedef struct {
        int         pre;
        logic [3:0] mask;
        logic [3:0] exp_gnt;
    } vec_t;
    vec_t tbl[11];

    lcd_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(TO), .PRIO0(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .valid       (valid),
        .last        (last),
        .data        (data),
        .gnt         (gnt),
        .ready       (ready),
        .wfull       (wfull),
        .winc        (winc),
        .wdata       (wdata),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    // Scoreboard and grant logger.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (winc === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wdata unexpected write got %05h", wdata);
            end else begin
                e = exp_q.pop_front();
                if (wdata !== e) begin
                    errors++;
                    $display("FAIL wdata got %05h exp %05h", wdata, e);
                end
            end
            if ((last & gnt & valid) != 0) last_cyc = cyc;
        end
        if (gnt != 0 && prev_gnt == 0) begin
            for (int i = 0; i < N; i++) if (gnt[i]) gnt_log.push_back(i);
            gap_log.push_back(cyc - last_cyc);
        end
        prev_gnt = gnt;
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, expv);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]         = src_en[i];
            valid[i]       = src_en[i] & ~src_mute[i];
            data[i*W +: W] = src_words[i][src_pos[i] % 8];
            last[i]        = ((src_pos[i] + 1) % src_blen[i]) == 0;
        end
        #1;
    endtask

    task automatic step();
        logic [N-1:0] acc, lst;
        @(negedge clk);
        acc = valid & ready;
        lst = last;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (lst[i] && src_pos[i] + 1 >= src_len[i]) src_en[i] = 1'b0;
                src_pos[i]++;
            end
        end
        drive();
    endtask

    task automatic clr_src();
        for (int i = 0; i < N; i++) begin
            src_en[i] = 1'b0; src_mute[i] = 1'b0; src_pos[i] = 0;
            src_len[i] = 1;   src_blen[i] = 1;
            for (int j = 0; j < 8; j++) src_words[i][j] = W'((i * 16 + j + 1) * 'h111);
        end
    endtask

    task automatic setup(int i, int len, int blen);
        src_en[i] = 1'b1; src_pos[i] = 0; src_len[i] = len; src_blen[i] = blen;
    endtask

    task automatic push_words(int i, int from, int n);
        for (int j = from; j < from + n; j++) exp_q.push_back(src_words[i][j]);
    endtask

    function automatic bit any_en();
        any_en = 1'b0;
        for (int i = 0; i < N; i++) if (src_en[i]) any_en = 1'b1;
    endfunction

    function automatic int log_at(int k);
        log_at = (k < gnt_log.size()) ? gnt_log[k] : -1;
    endfunction

    task automatic drain(string name);
        int k;
        k = 0;
        while ((any_en() || busy) && k < 300) begin
            step();
            k++;
        end
        chk(name, 32'(k < 300), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wfull = 1'b0;
        clr_src();
        drive();
        step();
        step();
        rst = 1'b0;
        drive();
        gnt_log.delete();
        gap_log.delete();
    endtask

    initial begin
        rst = 1'b1;
        wfull = 1'b0;
        clr_src();
        drive();
        step();
        step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_to", 32'(timeout_err), 0);
        chk("rst_winc", 32'(winc), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_wdata", 32'(wdata), 0);

        // Grant selection: {previous winner (-1 = fresh reset), request mask, grant}.
        tbl[0]  = '{-1, 4'b0010, 4'b0010};
        tbl[1]  = '{-1, 4'b1110, 4'b0010};
        tbl[2]  = '{-1, 4'b1111, 4'b0001};
        tbl[3]  = '{ 1, 4'b1110, 4'b0100};
        tbl[4]  = '{ 2, 4'b1010, 4'b1000};
        tbl[5]  = '{ 3, 4'b1010, 4'b0010};
        tbl[6]  = '{ 2, 4'b0010, 4'b0010};
        tbl[7]  = '{ 0, 4'b0011, 4'b0001};
        tbl[8]  = '{ 0, 4'b0110, 4'b0010};
        tbl[9]  = '{-1, 4'b0000, 4'b0000};
        tbl[10] = '{ 1, 4'b1101, 4'b0001};
        for (int v = 0; v < 11; v++) begin
            do_reset();
            if (tbl[v].pre >= 0) begin
                // Grant with no words, then drop req: sets rr_ptr, releases without error.
                src_en[tbl[v].pre] = 1'b1; src_mute[tbl[v].pre] = 1'b1;
                drive();
                step();
                chk($sformatf("tbl%0d_pre", v), 32'(gnt), 32'(1 << tbl[v].pre));
                src_en[tbl[v].pre] = 1'b0;
                drive();
                step();
                chk($sformatf("tbl%0d_droperr", v), 32'(timeout_err), 0);
                step();
            end
            for (int i = 0; i < N; i++) begin
                src_en[i] = tbl[v].mask[i]; src_mute[i] = 1'b1;
            end
            drive();
            step();
            chk($sformatf("tbl%0d_gnt", v), 32'(gnt), 32'(tbl[v].exp_gnt));
            chk($sformatf("tbl%0d_busy", v), 32'(busy), 32'(tbl[v].exp_gnt != 0));
            clr_src();
            drive();
            step();
            step();
        end

        // Single requester, three words.
        do_reset();
        src_words[1][0] = 17'h1002A; src_words[1][1] = 17'h00000; src_words[1][2] = 17'h000EF;
        setup(1, 3, 3);
        push_words(1, 0, 3);
        drive();
        chk("t1_pre_gnt", 32'(gnt), 0);
        step();
        chk("t1_gnt", 32'(gnt), 4'b0010);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t1_winc%0d", k), 32'(winc), 1);
            step();
        end
        chk("t1_rel_gnt", 32'(gnt), 0);
        chk("t1_rel_busy", 32'(busy), 1);
        chk("t1_rel_winc", 32'(winc), 0);
        step();
        chk("t1_idle_busy", 32'(busy), 0);

        // Round-robin over 1,2,3 with requester 1 coming back for a second burst.
        do_reset();
        setup(1, 4, 2); setup(2, 2, 2); setup(3, 2, 2);
        push_words(1, 0, 2); push_words(2, 0, 2); push_words(3, 0, 2); push_words(1, 2, 2);
        drive();
        drain("t2_drain");
        chk("t2_nlog", 32'(gnt_log.size()), 4);
        chk("t2_o0", 32'(log_at(0)), 1);
        chk("t2_o1", 32'(log_at(1)), 2);
        chk("t2_o2", 32'(log_at(2)), 3);
        chk("t2_o3", 32'(log_at(3)), 1);
        for (int k = 1; k < 4; k++)
            chk($sformatf("t2_gap%0d", k), 32'((k < gap_log.size()) ? gap_log[k] : -1), GAP_EXP);

        // Requester 0 arrives mid-burst: no preemption, but it beats 3 afterwards.
        do_reset();
        setup(2, 4, 4); setup(3, 1, 1);
        push_words(2, 0, 4); push_words(0, 0, 1); push_words(3, 0, 1);
        drive();
        step();
        chk("t3_gnt2", 32'(gnt), 4'b0100);
        step();
        setup(0, 1, 1);
        drive();
        step();
        chk("t3_hold_a", 32'(gnt), 4'b0100);
        step();
        chk("t3_hold_b", 32'(gnt), 4'b0100);
        drain("t3_drain");
        chk("t3_o0", 32'(log_at(0)), 2);
        chk("t3_o1", 32'(log_at(1)), 0);
        chk("t3_o2", 32'(log_at(2)), 3);

        // Back-pressure pattern during a two-word burst.
        do_reset();
        setup(1, 2, 2);
        push_words(1, 0, 2);
        drive();
        step();
        begin
            logic wf_pat[5];
            wf_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
            for (int k = 0; k < 5; k++) begin
                wfull = wf_pat[k];
                drive();
                chk($sformatf("t4_ready%0d", k), 32'(ready), wf_pat[k] ? 0 : 4'b0010);
                chk($sformatf("t4_winc%0d", k), 32'(winc), 32'(!wf_pat[k]));
                step();
            end
        end
        wfull = 1'b0;
        drive();
        chk("t4_rel_gnt", 32'(gnt), 0);
        chk("t4_sb", 32'(exp_q.size()), 0);
        drain("t4_drain");

        // Watchdog: granted requester never offers a word.
        do_reset();
        setup(1, 1, 1); src_mute[1] = 1'b1;
        setup(2, 1, 1);
        push_words(2, 0, 1);
        drive();
        step();
        chk("t5_gnt1", 32'(gnt), 4'b0010);
        for (int k = 1; k <= 14; k++) begin
            step();
            if (timeout_err !== 1'b0 || gnt !== 4'b0010)
                chk($sformatf("t5_early%0d", k), {timeout_err, 27'd0, gnt}, 32'(4'b0010));
        end
        chk("t5_pre_to", 32'(timeout_err), 0);
        step();
        chk("t5_to", 32'(timeout_err), 1);
        chk("t5_gnt0", 32'(gnt), 0);
        src_en[1] = 1'b0;
        drive();
        step();
        chk("t5_pulse", 32'(timeout_err), 0);
        drain("t5_drain");
        chk("t5_o1", 32'(log_at(1)), 2);

        // Reset in the second cycle of a five-word burst.
        do_reset();
        setup(2, 5, 5);
        push_words(2, 0, 2);
        drive();
        step();
        step();
        rst = 1'b1;
        drive();
        step();
        chk("t6_gnt", 32'(gnt), 0);
        chk("t6_winc", 32'(winc), 0);
        chk("t6_busy", 32'(busy), 0);
        clr_src();
        rst = 1'b0;
        setup(1, 1, 1); setup(3, 1, 1);
        push_words(1, 0, 1); push_words(3, 0, 1);
        drive();
        step();
        chk("t6_regnt", 32'(gnt), 4'b0010);
        drain("t6_drain");

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
